// File: rtl/regfile_sb.sv
// Dual-write, dual-read register file with per-register busy scoreboard for the
// pipelined MIPS datapath: optional zero register and same-cycle write bypass.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_stall,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NREG       = 2 ** ADDR_W;
  localparam int CNT_W      = ADDR_W + 1;
  localparam bit HAS_ZERO   = (ZERO_REG != 0);
  localparam bit USE_BYPASS = (BYPASS != 0);

  logic [DATA_W-1:0] regs_reg [NREG];
  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;
  logic [NREG-1:0]   clear_hit;
  logic [CNT_W-1:0]  busy_count_reg;
  logic [CNT_W-1:0]  busy_count_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      localparam bit IS_ZERO = HAS_ZERO && (gi == 0);
      logic hit0;
      logic hit1;
      logic set_hit;

      assign hit0          = wr_en0 && (wr_addr0 == ADDR_W'(gi));
      assign hit1          = wr_en1 && (wr_addr1 == ADDR_W'(gi));
      assign clear_hit[gi] = hit0 || hit1;
      assign set_hit       = issue_en && !issue_stall && (issue_addr == ADDR_W'(gi));

      // A newly issued producer replaces one retiring in the same cycle.
      assign busy_next[gi] = IS_ZERO        ? 1'b0 :
                             set_hit        ? 1'b1 :
                             clear_hit[gi]  ? 1'b0 : busy_reg[gi];

      // Port 0 has priority when both ports target this register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          regs_reg[gi] <= '0;
        end else if (!IS_ZERO && hit0) begin
          regs_reg[gi] <= wr_data0;
        end else if (!IS_ZERO && hit1) begin
          regs_reg[gi] <= wr_data1;
        end
      end
    end
  endgenerate

  // WAW guard: an outstanding producer that is not retiring this cycle blocks issue.
  assign issue_stall = reset && issue_en && busy_reg[issue_addr] && !clear_hit[issue_addr];

  always_comb begin
    busy_count_next = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_count_next = busy_count_next + CNT_W'(busy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg       <= '0;
      busy_count_reg <= '0;
    end else begin
      busy_reg       <= busy_next;
      busy_count_reg <= busy_count_next;
    end
  end

  assign busy_count = busy_count_reg;

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = regs_reg[addr];
    if (HAS_ZERO && (addr == '0)) begin
      value = '0;
    end else if (USE_BYPASS && wr_en0 && (wr_addr0 == addr)) begin
      value = wr_data0;
    end else if (USE_BYPASS && wr_en1 && (wr_addr1 == addr)) begin
      value = wr_data1;
    end
    return value;
  endfunction

  // Gated by reset so bypassed write data cannot leak out while reset is held.
  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    rd_busy1 = 1'b0;
    rd_busy2 = 1'b0;
    if (reset) begin
      rd_data1 = read_port(rd_addr1);
      rd_data2 = read_port(rd_addr2);
      rd_busy1 = busy_reg[rd_addr1] && !(USE_BYPASS && clear_hit[rd_addr1]);
      rd_busy2 = busy_reg[rd_addr2] && !(USE_BYPASS && clear_hit[rd_addr2]);
    end
  end

endmodule
